frame_parser: RTL and testbench

- Downstream consumer of the start-byte decoder.
- Pops bytes from the read user buffer (show-ahead FIFO) and waits for the decoder's start indication. It then collects a 16-bit big-endian length, streams exactly that many payload bytes to the next stage with a valid/ready handshake, and checks a trailing end byte.
- Reports frame completion or error to the host-facing control logic.

---
 rtl/frame_parser_if.sv | 32 +++
 rtl/frame_parser.sv | 124 ++++++++++++
 tb/tb_frame_parser.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_parser_if.sv
// Byte-stream handshake between the read user buffer, the parser and the
// downstream payload consumer. The parser uses the slave view; whatever
// feeds the buffer and drains the payload uses the master view.
interface frame_parser_if;
  logic [7:0] read_user_buffer_output_data;
  logic       read_user_buffer_empty;
  logic       start;
  logic       read_user_buffer_read;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output read_user_buffer_output_data,
    output read_user_buffer_empty,
    output start,
    output out_ready,
    input  read_user_buffer_read,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  read_user_buffer_output_data,
    input  read_user_buffer_empty,
    input  start,
    input  out_ready,
    output read_user_buffer_read,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/frame_parser.sv
// frame_parser: pops bytes from a show-ahead buffer, waits for a start byte,
// reads a 16-bit big-endian length, forwards that many payload bytes and
// checks the trailer byte. Optional stall timeout: define FRAME_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | dropping bytes until the start byte is at head
// LEN_HI  | next pop is the length high byte
// LEN_LO  | next pop is the length low byte
// PAYLOAD | forwarding payload bytes, counter = bytes left
// TRAILER | next pop is the end byte, pulse done or error
module frame_parser #(
  parameter int         LEN_W          = 16,
  parameter logic [7:0] END_BYTE       = 8'h45,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  frame_parser_if.slave    bus,
  output logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_error
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, PAYLOAD, TRAILER} state_t;

  state_t           state;
  logic [LEN_W-1:0] counter;
  logic             pop;
  logic [7:0]       byte_in;
  logic [LEN_W-1:0] len_full;

  assign byte_in  = bus.read_user_buffer_output_data;
  assign len_full = {frame_len[LEN_W-1:8], byte_in};

  // Pop decision: header/trailer bytes go whenever present, payload waits on downstream.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE, LEN_HI, LEN_LO, TRAILER: pop = !bus.read_user_buffer_empty;
      PAYLOAD:                       pop = !bus.read_user_buffer_empty && bus.out_ready;
      default:                       pop = 1'b0;
    endcase
  end

  assign bus.read_user_buffer_read = pop;
  assign bus.out_data              = byte_in;
  assign bus.out_valid             = (state == PAYLOAD) && !bus.read_user_buffer_empty;

`ifdef FRAME_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [STALL_W-1:0] stall_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // Frame FSM with registered status outputs; advances only on pop cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      frame_len   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      stall_cnt   <= '0;
`endif
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (pop) begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state <= LEN_HI;
              busy  <= 1'b1;
            end
          end
          LEN_HI: begin
            frame_len[LEN_W-1:8] <= byte_in;
            state                <= LEN_LO;
          end
          LEN_LO: begin
            frame_len[7:0] <= byte_in;
            counter        <= len_full;
            state          <= (len_full == '0) ? TRAILER : PAYLOAD;
          end
          PAYLOAD: begin
            counter <= counter - LEN_W'(1);
            if (counter == LEN_W'(1)) state <= TRAILER;
          end
          TRAILER: begin
            if (byte_in == END_BYTE) frame_done  <= 1'b1;
            else                     frame_error <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
`ifdef FRAME_TIMEOUT_EN
      // A stalled frame is abandoned; timing out only happens on a no-pop cycle.
      if (pop || !busy) begin
        stall_cnt <= '0;
      end else if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
        stall_cnt   <= '0;
        counter     <= '0;
        state       <= IDLE;
        busy        <= 1'b0;
        frame_error <= 1'b1;
      end else begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_frame_parser.sv
// Bench for frame_parser: directed and random byte streams fed through a
// modelled show-ahead buffer, checked against a stream-level frame model.
module tb_frame_parser;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] frame_len;
  logic        busy, frame_done, frame_error;

  frame_parser_if bus ();

  frame_parser #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .frame_len   (frame_len),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  localparam int K_DROP = 0, K_START = 1, K_HI = 2, K_LO = 3, K_PAY = 4, K_TOK = 5, K_TBAD = 6;

  int checks   = 0;
  int failures = 0;

  // Stream under test and the per-byte expectations derived from it.
  logic [7:0]  sq[$];
  int          kind[$];
  bit          bsy[$];
  logic [15:0] fla[$];
  logic [7:0]  exp_pay[$];

  logic [15:0] cur_fl   = 16'h0;
  bit          cur_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk the byte stream as frames: role of each byte, busy and frame_len after its pop.
  function automatic void build_model(input logic [15:0] fl0);
    int          i = 0;
    int          n = sq.size();
    logic [15:0] fl = fl0;
    int          len;
    kind.delete(); bsy.delete(); fla.delete(); exp_pay.delete();
    while (i < n) begin
      if (sq[i] != 8'h53) begin
        kind.push_back(K_DROP); bsy.push_back(1'b0); fla.push_back(fl); i++;
        continue;
      end
      kind.push_back(K_START); bsy.push_back(1'b1); fla.push_back(fl); i++;
      if (i >= n) break;
      fl[15:8] = sq[i];
      kind.push_back(K_HI); bsy.push_back(1'b1); fla.push_back(fl); i++;
      if (i >= n) break;
      fl[7:0] = sq[i];
      kind.push_back(K_LO); bsy.push_back(1'b1); fla.push_back(fl); i++;
      len = int'(fl);
      for (int k = 0; k < len && i < n; k++) begin
        kind.push_back(K_PAY); bsy.push_back(1'b1); fla.push_back(fl);
        exp_pay.push_back(sq[i]); i++;
      end
      if (i >= n) break;
      kind.push_back(sq[i] == 8'h45 ? K_TOK : K_TBAD); bsy.push_back(1'b0); fla.push_back(fl); i++;
    end
  endfunction

  // ready_mode: 0 always ready, 1 random ready, 2 ready on every third cycle.
  task automatic run_stream(input int ready_mode, input bit bubbles, input int max_cycles);
    int         head = 0;
    int         n    = sq.size();
    int         cyc  = 0;
    bit         popped, hide, exp_pop, exp_valid;
    bit         ed, ee;
    logic [7:0] got[$];
    build_model(cur_fl);
    while (head < n && cyc < max_cycles) begin
      @(negedge clk);
      hide = bubbles && ($urandom_range(0, 3) == 0);
      if (!hide) begin
        bus.read_user_buffer_empty       = 1'b0;
        bus.read_user_buffer_output_data = sq[head];
        bus.start                        = (sq[head] == 8'h53);
      end else begin
        bus.read_user_buffer_empty       = 1'b1;
        bus.read_user_buffer_output_data = 8'h00;
        bus.start                        = 1'b0;
      end
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = (cyc % 3 == 0);
      endcase
      #1;
      exp_valid = !hide && kind[head] == K_PAY;
      exp_pop   = !hide && (kind[head] != K_PAY || bus.out_ready);
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("pop", 32'(bus.read_user_buffer_read), 32'(exp_pop));
      if (bus.out_valid) chk("out_data", 32'(bus.out_data), 32'(sq[head]));
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      popped = bus.read_user_buffer_read;
      @(posedge clk);
      #1;
      bus.read_user_buffer_empty = 1'b1;
      bus.start                  = 1'b0;
      ed = 1'b0;
      ee = 1'b0;
      if (popped) begin
        cur_busy = bsy[head];
        cur_fl   = fla[head];
        ed       = (kind[head] == K_TOK);
        ee       = (kind[head] == K_TBAD);
        head++;
      end
      chk("busy", 32'(busy), 32'(cur_busy));
      chk("frame_len", 32'(frame_len), 32'(cur_fl));
      chk("frame_done", 32'(frame_done), 32'(ed));
      chk("frame_error", 32'(frame_error), 32'(ee));
      cyc++;
    end
    chk("stream_drained", 32'(head), 32'(n));
    chk("payload_count", 32'(got.size()), 32'(exp_pay.size()));
    for (int i = 0; i < got.size() && i < exp_pay.size(); i++)
      chk("payload_byte", 32'(got[i]), 32'(exp_pay[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_frame_len"}, 32'(frame_len), 32'(0));
    chk({tag, "_frame_done"}, 32'(frame_done), 32'(0));
    chk({tag, "_frame_error"}, 32'(frame_error), 32'(0));
    chk({tag, "_pop"}, 32'(bus.read_user_buffer_read), 32'(0));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
  endtask

  initial begin
    logic [7:0] b;
    int         nj, len;
`ifdef FRAME_TIMEOUT_EN
    int         to_cycle;
`endif
    reset                            = 1'b1;
    bus.read_user_buffer_empty       = 1'b1;
    bus.read_user_buffer_output_data = 8'h00;
    bus.start                        = 1'b0;
    bus.out_ready                    = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    sq = '{8'h53, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h45};
    run_stream(0, 1'b0, 40);

    sq = '{8'h11, 8'h22, 8'h53, 8'h00, 8'h00, 8'h45};
    run_stream(0, 1'b0, 40);

    sq = '{8'h53, 8'h00, 8'h02, 8'h01, 8'h02, 8'h46};
    run_stream(0, 1'b0, 40);

    sq = '{8'h53, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h45};
    run_stream(2, 1'b0, 60);

    // Abort mid-payload, then a clean frame from IDLE.
    sq = '{8'h53, 8'h00, 8'h05, 8'hA1, 8'hA2};
    run_stream(0, 1'b0, 40);
    chk("midframe_busy", 32'(busy), 32'(1));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    reset    = 1'b0;
    cur_fl   = 16'h0;
    cur_busy = 1'b0;
    sq = '{8'h53, 8'h00, 8'h01, 8'h77, 8'h45};
    run_stream(0, 1'b0, 40);

    // Random frames with junk, stray trailers, downstream stalls and buffer bubbles.
    sq.delete();
    for (int f = 0; f < 20; f++) begin
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom);
        if (b == 8'h53) b = 8'h00;
        sq.push_back(b);
      end
      len = $urandom_range(0, 12);
      sq.push_back(8'h53);
      sq.push_back(8'h00);
      sq.push_back(8'(len));
      for (int j = 0; j < len; j++) sq.push_back(8'($urandom));
      sq.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h45);
    end
`ifdef FRAME_TIMEOUT_EN
    run_stream(1, 1'b0, sq.size() * 8 + 50);
`else
    run_stream(1, 1'b1, sq.size() * 8 + 50);
`endif

    // Largest length: 65535 payload bytes, counter must reach the trailer exactly.
    sq = '{8'h53, 8'hFF, 8'hFF};
    for (int k = 0; k < 65535; k++) sq.push_back(8'($urandom));
    sq.push_back(8'h45);
    run_stream(0, 1'b0, sq.size() + 20);

`ifdef FRAME_TIMEOUT_EN
    sq = '{8'h53, 8'h00, 8'h02, 8'h01};
    run_stream(0, 1'b0, 40);
    to_cycle = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.read_user_buffer_empty = 1'b1;
      @(posedge clk);
      #1;
      if (frame_error) begin
        to_cycle = k;
        break;
      end
    end
    chk("timeout_cycle", 32'(to_cycle), 32'(8));
    chk("timeout_busy", 32'(busy), 32'(0));
    cur_busy = 1'b0;
    sq = '{8'h53, 8'h00, 8'h01, 8'h5A, 8'h45};
    run_stream(0, 1'b0, 40);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
